branch_cmp_arbiter: RTL and testbench

// - Shares one branch comparator (eq / signed-lt / unsigned-lt) between two requesters.
//   - Port 0: branch resolution.
//   - Port 1: SLT/SLTU issue path.
// - Valid/ready request handshake per port; round-robin grant.
// - Operands and results are registered; one response channel tagged with requester id.
// - Sits between the decode/branch control logic and the shared compare resource.

---
 rtl/branch_cmp_arbiter.sv | 133 +++++++++++++
 tb/tb_branch_cmp_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cmp_arbiter.sv
// Shares one eq/slt/sltu comparator between two requesters; round-robin grant (BR_CMP_FIXED_PRIO_EN: port 0 always wins).
// Latency: handshake in cycle N -> rsp_valid in N+2; response held until rsp_ready; no accept outside IDLE.
module branch_cmp_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r0_valid,
    output logic            r0_ready,
    input  logic [XLEN-1:0] r0_a,
    input  logic [XLEN-1:0] r0_b,
    input  logic            r0_un,
    input  logic            r1_valid,
    output logic            r1_ready,
    input  logic [XLEN-1:0] r1_a,
    input  logic [XLEN-1:0] r1_b,
    input  logic            r1_un,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic            rsp_eq,
    output logic            rsp_lt,
    input  logic            rsp_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            un_q;
    logic            id_q;
    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic            eq_q;
    logic            lt_q;

    logic            last_gnt;
    logic [1:0]      gnt;
    logic            hs0;
    logic            hs1;
    logic [XLEN-1:0] a_d;
    logic [XLEN-1:0] b_d;
    logic            un_d;

`ifdef BR_CMP_FIXED_PRIO_EN
    // Pretending port 1 won last makes port 0 win every contention.
    assign last_gnt = 1'b1;
`else
    logic last_gnt_q;
    assign last_gnt = last_gnt_q;
`endif

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = r0_valid & (~r1_valid | last_gnt);
        gnt[1] = r1_valid & (~r0_valid | ~last_gnt);
    end

    assign r0_ready = (state_q == ST_IDLE) & ~rst & gnt[0];
    assign r1_ready = (state_q == ST_IDLE) & ~rst & gnt[1];
    assign hs0      = r0_valid & r0_ready;
    assign hs1      = r1_valid & r1_ready;

    always_comb begin
        a_d  = r0_a;
        b_d  = r0_b;
        un_d = r0_un;
        if (hs1) begin
            a_d  = r1_a;
            b_d  = r1_b;
            un_d = r1_un;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            un_q        <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
`ifndef BR_CMP_FIXED_PRIO_EN
            last_gnt_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs0 | hs1) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        un_q    <= un_d;
                        id_q    <= hs1;
                        state_q <= ST_CMP;
`ifndef BR_CMP_FIXED_PRIO_EN
                        last_gnt_q <= hs1;
`endif
                    end
                end
                ST_CMP: begin
                    eq_q        <= (a_q == b_q);
                    lt_q        <= un_q ? (a_q < b_q) : ($signed(a_q) < $signed(b_q));
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_eq    = eq_q;
    assign rsp_lt    = lt_q;

endmodule

// File: tb/tb_branch_cmp_arbiter.sv
// Randomized + directed bench for branch_cmp_arbiter against a cycle-indexed transaction model.
module tb_branch_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r0_un;
    logic [31:0] r0_a, r0_b;
    logic        r1_valid, r1_ready, r1_un;
    logic [31:0] r1_a, r1_b;
    logic        rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ready;

    always #5 clk = ~clk;

    branch_cmp_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_un(r0_un),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_un(r1_un),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt),
        .rsp_ready(rsp_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction, response due two cycles after acceptance.
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_issue = 0;
    bit          m_id, m_un;
    logic [31:0] m_a, m_b;
    bit          m_last = 1;
    bit          m_zero = 1;
    bit          hs0, hs1, s_rv;

    function automatic bit ref_lt(input logic [31:0] a, input logic [31:0] b, input bit un);
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (un) return a < b;
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && !v1) return 1'b0;
        if (v1 && !v0) return 1'b1;
`ifdef BR_CMP_FIXED_PRIO_EN
        return 1'b0;
`else
        return ~last;
`endif
    endfunction

    task automatic step();
        bit e0, e1, erv, w;
        @(negedge clk);
        e0 = 0; e1 = 0;
        if (!rst && !m_busy && (r0_valid || r1_valid)) begin
            w  = pick(r0_valid, r1_valid, m_last);
            e0 = (w == 1'b0);
            e1 = (w == 1'b1);
        end
        chk("r0_ready", r0_ready, e0);
        chk("r1_ready", r1_ready, e1);
        erv = m_busy && (cyc >= m_issue + 2);
        chk("rsp_valid", rsp_valid, erv);
        if (erv) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_eq", rsp_eq, m_a == m_b);
            chk("rsp_lt", rsp_lt, ref_lt(m_a, m_b, m_un));
            m_zero = 0;
        end else if (m_zero) begin
            chk("rsp_id_rst", rsp_id, 0);
            chk("rsp_eq_rst", rsp_eq, 0);
            chk("rsp_lt_rst", rsp_lt, 0);
        end
        s_rv = rsp_valid;
        hs0  = r0_valid && e0;
        hs1  = r1_valid && e1;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy = 0; m_last = 1; m_zero = 1;
        end else if (hs0 || hs1) begin
            m_busy  = 1;
            m_issue = cyc - 1;
            m_id    = hs1;
            m_a     = hs1 ? r1_a : r0_a;
            m_b     = hs1 ? r1_b : r0_b;
            m_un    = hs1 ? r1_un : r0_un;
            m_last  = hs1;
        end else if (erv && rsp_ready) begin
            m_busy = 0;
        end
        #1;
    endtask

    // Directed transaction: constant expectations plus an explicit latency count.
    task automatic txn(input bit port, input logic [31:0] a, input logic [31:0] b, input bit un,
                       input bit xeq, input bit xlt);
        int n;
        if (port) begin r1_valid = 1; r1_a = a; r1_b = b; r1_un = un; end
        else      begin r0_valid = 1; r0_a = a; r0_b = b; r0_un = un; end
        n = 0;
        do begin step(); n++; end while (!(hs0 || hs1) && n < 20);
        chk("txn_accept", hs0 || hs1, 1);
        r0_valid = 0; r1_valid = 0;
        n = 0;
        do begin step(); n++; end while (!s_rv && n < 10);
        chk("txn_latency", n, 2);
        chk("txn_id", rsp_id, port);
        chk("txn_eq", rsp_eq, xeq);
        chk("txn_lt", rsp_lt, xlt);
        step();
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    bit order [$];
    bit exp_order [4];
    int n;

    initial begin
        rst = 1; rsp_ready = 1;
        r0_valid = 0; r0_a = 0; r0_b = 0; r0_un = 0;
        r1_valid = 0; r1_a = 0; r1_b = 0; r1_un = 0;
        @(posedge clk); #1;
        r0_valid = 1; r0_a = 5; r0_b = 5;
        step(); step();
        rst = 0;
        step();
        chk("first_ready", hs0, 1);
        r0_valid = 0;
        repeat (4) step();

        txn(0, 32'd5, 32'd5, 0, 1, 0);
        txn(1, 32'hFFFF_FFFF, 32'd1, 0, 0, 1);
        txn(1, 32'hFFFF_FFFF, 32'd1, 1, 0, 0);
        txn(0, 32'h8000_0000, 32'd0, 0, 0, 1);
        txn(0, 32'h8000_0000, 32'd0, 1, 0, 0);

        // Contention: last grant went to port 0, so port 1 first... reset it via a port-1 txn.
        txn(1, 32'd3, 32'd7, 1, 0, 1);
        r0_valid = 1; r1_valid = 1;
        n = 0;
        while (order.size() < 4 && n < 60) begin
            step(); n++;
            if (hs0) begin order.push_back(1'b0); r0_a = $urandom; r0_b = $urandom; end
            if (hs1) begin order.push_back(1'b1); r1_a = $urandom; r1_b = $urandom; end
        end
        r0_valid = 0; r1_valid = 0;
        chk("order_count", order.size(), 4);
`ifdef BR_CMP_FIXED_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int i = 0; i < 4; i++)
            if (i < order.size()) chk($sformatf("order_%0d", i), order[i], exp_order[i]);
        repeat (4) step();

        // Stalled response with both requesters waiting.
        rsp_ready = 0;
        r0_valid = 1; r0_a = 32'h1234; r0_b = 32'h1234; r0_un = 0;
        n = 0;
        do begin step(); n++; end while (!hs0 && n < 20);
        r1_valid = 1; r1_a = 9; r1_b = 2;
        repeat (6) step();
        chk("stall_valid", rsp_valid, 1);
        chk("stall_eq", rsp_eq, 1);
        rsp_ready = 1;
        step();
        r0_valid = 0; r1_valid = 0;
        repeat (8) step();

        // Reset during CMP drops the transaction.
        r0_valid = 1; r0_a = 1; r0_b = 2; r0_un = 1;
        n = 0;
        do begin step(); n++; end while (!hs0 && n < 20);
        r0_valid = 0;
        rst = 1; step(); rst = 0;
        repeat (4) step();
        txn(0, 32'd2, 32'd1, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rsp_ready = ($urandom % 4) != 0;
            rst = ($urandom % 200) == 0;
            step();
            if (hs0 || !r0_valid) begin
                r0_valid = $urandom % 2; r0_a = rand_op(); r0_un = $urandom % 2;
                r0_b = ($urandom % 4 == 0) ? r0_a : rand_op();
            end
            if (hs1 || !r1_valid) begin
                r1_valid = $urandom % 2; r1_a = rand_op(); r1_un = $urandom % 2;
                r1_b = ($urandom % 4 == 0) ? r1_a : rand_op();
            end
        end
        rst = 0; rsp_ready = 1; r0_valid = 0; r1_valid = 0;
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
